// File: rtl/key_conditioner.sv
// key_conditioner: per-channel input conditioning for raw pushbuttons/switches.
// Each channel double-flop synchronises its raw input, debounces it with a
// stability counter and derives a clean level, press/release pulses and a
// long-press hold flag with auto-repeat pulses. Channels are independent.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module key_conditioner #(
    parameter int N               = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] raw_in,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] hold,
    output logic [N-1:0] rpt
);

    // Polarity fold: after XOR, 1 always means "pressed".
    localparam logic POL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DCNT_ONE = DW'(1);

    // Hold counter is shared between the long-press and repeat phases.
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX < 2) ? 1 : $clog2(HMAX);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] REP_MAX  = HW'(REPEAT_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_ONE = HW'(1);

    for (genvar ch = 0; ch < N; ch++) begin : g_ch
        logic          sync1_r;
        logic          sync2_r;
        logic [DW-1:0] dcnt_r;
        logic [DW-1:0] dcnt_next_s;
        logic          level_r;
        logic          level_next_s;
        logic          press_r;
        logic          press_next_s;
        logic          release_r;
        logic          release_next_s;
        logic [HW-1:0] hcnt_r;
        logic [HW-1:0] hcnt_next_s;
        logic          hold_r;
        logic          hold_next_s;
        logic          rpt_r;
        logic          rpt_next_s;
        logic          falling_s;

        // Debounce: level follows the synchronised input only after it has
        // differed from level for DEBOUNCE_CYCLES consecutive evaluations.
        always_comb begin
            dcnt_next_s    = '0;
            level_next_s   = level_r;
            press_next_s   = 1'b0;
            release_next_s = 1'b0;
            falling_s      = 1'b0;
            if (sync2_r == level_r) begin
                dcnt_next_s = '0;
            end else if (dcnt_r == DCNT_MAX) begin
                dcnt_next_s    = '0;
                level_next_s   = sync2_r;
                press_next_s   = sync2_r;
                release_next_s = ~sync2_r;
                falling_s      = ~sync2_r;
            end else begin
                dcnt_next_s = dcnt_r + DCNT_ONE;
            end
        end

        // Long-press / auto-repeat: hold is cleared on the same edge level
        // falls, so that edge never produces a repeat pulse.
        always_comb begin
            hcnt_next_s = '0;
            hold_next_s = 1'b0;
            rpt_next_s  = 1'b0;
            if (falling_s || !level_r) begin
                hcnt_next_s = '0;
                hold_next_s = 1'b0;
            end else if (!hold_r) begin
                if (hcnt_r == LONG_MAX) begin
                    hold_next_s = 1'b1;
                    rpt_next_s  = 1'b1;
                    hcnt_next_s = '0;
                end else begin
                    hold_next_s = 1'b0;
                    hcnt_next_s = hcnt_r + HCNT_ONE;
                end
            end else begin
                hold_next_s = 1'b1;
                if (hcnt_r == REP_MAX) begin
                    rpt_next_s  = 1'b1;
                    hcnt_next_s = '0;
                end else begin
                    hcnt_next_s = hcnt_r + HCNT_ONE;
                end
            end
        end

        // State and output registers; reset clears all to the not-pressed state.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync1_r   <= 1'b0;
                sync2_r   <= 1'b0;
                dcnt_r    <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                hcnt_r    <= '0;
                hold_r    <= 1'b0;
                rpt_r     <= 1'b0;
            end else begin
                sync1_r   <= raw_in[ch] ^ POL;
                sync2_r   <= sync1_r;
                dcnt_r    <= dcnt_next_s;
                level_r   <= level_next_s;
                press_r   <= press_next_s;
                release_r <= release_next_s;
                hcnt_r    <= hcnt_next_s;
                hold_r    <= hold_next_s;
                rpt_r     <= rpt_next_s;
            end
        end

        assign level[ch]         = level_r;
        assign press[ch]         = press_r;
        assign release_pulse[ch] = release_r;
        assign hold[ch]          = hold_r;
        assign rpt[ch]           = rpt_r;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: table-driven, scoreboarded bench for key_conditioner
// with DEBOUNCE_CYCLES=4, LONG_CYCLES=10, REPEAT_CYCLES=3, active-low inputs.
// Vector k is driven before clock edge k and checked just after it.
module tb_key_conditioner;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] raw_in;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;
    logic [N-1:0] hold;
    logic [N-1:0] rpt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .N(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .level(level), .press(press),
        .release_pulse(release_pulse), .hold(hold), .rpt(rpt)
    );

    typedef struct {
        logic       rst_n;
        logic [1:0] raw;
        logic [9:0] exp;   // {level, press, release, hold, rpt}
        string      name;
        int         idx;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    function automatic void add(input logic r, input logic [1:0] raw, input logic [1:0] lvl,
                                input logic [1:0] prs, input logic [1:0] rel, input logic [1:0] hld,
                                input logic [1:0] rp, input string nm, input int k);
        vec_t v;
        v.rst_n = r;
        v.raw   = raw;
        v.exp   = {lvl, prs, rel, hld, rp};
        v.name  = nm;
        v.idx   = k;
        tbl.push_back(v);
    endfunction

    // Reset pulse followed by idle cycles with both keys released.
    function automatic void add_reset(input string nm);
        for (int i = 0; i < 2; i++) add(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, {nm, "_rst"}, i);
        for (int i = 0; i < 3; i++) add(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, {nm, "_idle"}, i);
    endfunction

    task automatic check(input string nm, input int k, input logic [9:0] act, input logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got lvl=%b prs=%b rel=%b hld=%b rpt=%b, want lvl=%b prs=%b rel=%b hld=%b rpt=%b",
                     nm, k, act[9:8], act[7:6], act[5:4], act[3:2], act[1:0],
                     exp[9:8], exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    // Drive each vector at the falling edge, compare just after the rising edge.
    task automatic apply();
        vec_t v;
        vec_t e;
        foreach (tbl[i]) begin
            @(negedge clk);
            v = tbl[i];
            reset_n = v.rst_n;
            raw_in  = v.raw;
            sb.push_back(v);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: queue empty at vector %0d, want 1 entry", i);
            end else begin
                e = sb.pop_front();
                check(e.name, e.idx, {level, press, release_pulse, hold, rpt}, e.exp);
            end
        end
        tbl.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        raw_in  = 2'b11;

        // 1. Reset with both keys pressed: zero during reset, fresh press 6 edges after release.
        for (int i = 0; i < 3; i++) add(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "s1_in_reset", i);
        for (int k = 1; k <= 9; k++)
            add(1'b1, 2'b00, (k >= 6) ? 2'b11 : 2'b00, (k == 6) ? 2'b11 : 2'b00,
                2'b00, 2'b00, 2'b00, "s1_after_reset", k);
        apply();

        // 2. Clean press on ch0.
        add_reset("s2");
        for (int k = 1; k <= 9; k++)
            add(1'b1, 2'b10, {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, 2'b00, 2'b00, "s2_press", k);
        apply();

        // 3. Bounce: toggling for 8 cycles, then stable low from vector 9.
        add_reset("s3");
        for (int k = 1; k <= 18; k++)
            add(1'b1, {1'b1, (k <= 8) ? ((k % 2) == 0) : 1'b0}, {1'b0, k >= 14}, {1'b0, k == 14},
                2'b00, 2'b00, 2'b00, "s3_bounce", k);
        apply();

        // 4. Long press, then release timed so the drop edge lands on a repeat slot.
        add_reset("s4");
        for (int k = 1; k <= 46; k++)
            add(1'b1, {1'b1, k >= 38}, {1'b0, (k >= 6) && (k <= 42)}, {1'b0, k == 6},
                {1'b0, k == 43}, {1'b0, (k >= 16) && (k <= 42)},
                {1'b0, (k >= 16) && (k <= 42) && (((k - 16) % 3) == 0)}, "s4_long", k);
        apply();

        // 5. Release glitches of 2 and 3 cycles while held: no release, cadence kept.
        add_reset("s5");
        for (int k = 1; k <= 32; k++)
            add(1'b1, {1'b1, (k == 20) || (k == 21) || (k == 24) || (k == 25) || (k == 26)},
                {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k >= 16},
                {1'b0, (k >= 16) && (((k - 16) % 3) == 0)}, "s5_glitch", k);
        apply();

        // 7. Independent channels: ch1 press/release overlapping ch0 hold onset.
        add_reset("s7");
        for (int k = 1; k <= 20; k++)
            add(1'b1, {!((k >= 3) && (k <= 10)), 1'b0},
                {(k >= 8) && (k <= 15), k >= 6}, {k == 8, k == 6}, {k == 16, 1'b0},
                {1'b0, k >= 16}, {1'b0, (k == 16) || (k == 19)}, "s7_indep", k);
        apply();

        // 6. Asynchronous reset mid-hold.
        add_reset("s6");
        for (int k = 1; k <= 20; k++)
            add(1'b1, 2'b10, {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k >= 16},
                {1'b0, (k == 16) || (k == 19)}, "s6_prehold", k);
        apply();
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_async_clear", 0, {level, press, release_pulse, hold, rpt}, 10'b0);
        for (int i = 0; i < 2; i++) add(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "s6_in_reset", i);
        for (int k = 1; k <= 18; k++)
            add(1'b1, 2'b10, {1'b0, k >= 6}, {1'b0, k == 6}, 2'b00, {1'b0, k >= 16},
                {1'b0, k == 16}, "s6_after_reset", k);
        apply();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
